// File: rtl/icache_refill_controller.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_controller
// Description : I-cache fetch/refill FSM. Hits return one cycle after the
//               lookup; misses refill the whole line with a pipelined burst of
//               up to MAX_OUTSTANDING overlapping word loads, then write the
//               line to the cache and forward it to the fetch unit.
//               Optional feature macro: CRITICAL_WORD_FIRST_EN (refill starts
//               at the PC word and the first returned word is forwarded early).
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_controller #(
    parameter int BLOCK_WORDS     = 8,
    parameter int INDEX           = 12,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic                      invalidate_i,
    input  logic                      fetch_i,
    input  logic [31:0]               program_counter_i,
    output logic [BLOCK_WORDS*32-1:0] instruction_o,
    output logic                      valid_o,
    output logic                      stall_fetch_o,
    output logic [31:0]               word_o,
    output logic                      word_valid_o,
    output logic                      cache_read_o,
    output logic [31:0]               cache_read_address_o,
    input  logic                      cache_hit_i,
    input  logic [BLOCK_WORDS*32-1:0] cache_instruction_i,
    output logic                      cache_write_o,
    output logic [31:0]               cache_write_address_o,
    output logic [BLOCK_WORDS*32-1:0] cache_instruction_o,
    output logic                      load_request_o,
    output logic [31:0]               load_address_o,
    input  logic                      load_ready_i,
    input  logic                      load_valid_i,
    input  logic [31:0]               load_data_i,
    output logic                      load_invalidate_o
);

    localparam int c_OFFSET = $clog2(BLOCK_WORDS);
    localparam int c_TAG    = 30 - INDEX - c_OFFSET;
    localparam int c_CW     = c_OFFSET + 1;                 // holds 0..BLOCK_WORDS
    localparam int c_OW     = $clog2(MAX_OUTSTANDING + 1);  // holds 0..MAX_OUTSTANDING

    localparam logic [c_CW-1:0] c_BW  = c_CW'(BLOCK_WORDS);
    localparam logic [c_OW-1:0] c_MAX = c_OW'(MAX_OUTSTANDING);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_LOOKUP   = 3'd1;
    localparam logic [2:0] c_ST_REFILL   = 3'd2;
    localparam logic [2:0] c_ST_ALLOCATE = 3'd3;
    localparam logic [2:0] c_ST_DRAIN    = 3'd4;

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [29:0]               r_pc;            // latched fetch word address
    logic [c_CW-1:0]           r_issue_cnt;
    logic [c_CW-1:0]           r_resp_cnt;
    logic [c_CW-1:0]           w_resp_cnt_nxt;
    logic [c_OW-1:0]           r_outstanding;
    logic [c_OW-1:0]           w_outstanding_nxt;
    logic                      r_abort;
    logic [31:0]               r_buf [BLOCK_WORDS];
    logic [c_OFFSET-1:0]       w_start;
    logic [c_OFFSET-1:0]       w_issue_ptr;
    logic [c_OFFSET-1:0]       w_resp_ptr;
    logic                      w_issue_window;
    logic                      w_accept;
    logic                      w_resp_take;
    logic                      w_refill_resp;
    logic                      w_lookup_hit;
    logic [BLOCK_WORDS*32-1:0] w_line;
    logic [31:0]               w_line_base;

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start = r_pc[c_OFFSET-1:0];
`else
    assign w_start = '0;
`endif

    // Offsets wrap naturally in c_OFFSET bits, giving the mod-BLOCK_WORDS order.
    assign w_issue_ptr = w_start + r_issue_cnt[c_OFFSET-1:0];
    assign w_resp_ptr  = w_start + r_resp_cnt[c_OFFSET-1:0];
    assign w_line_base = {r_pc[29 -: (c_TAG + INDEX)], {c_OFFSET{1'b0}}, 2'b00};

    // A request may go out from the miss cycle of LOOKUP onward, while the burst
    // is neither aborted, stalled, window-limited nor complete.
    assign w_issue_window = ((r_state == c_ST_REFILL) ||
                             ((r_state == c_ST_LOOKUP) && !cache_hit_i))
                            && !r_abort && !invalidate_i && !stall_i
                            && (r_outstanding < c_MAX) && (r_issue_cnt < c_BW);
    assign w_accept       = w_issue_window && load_ready_i;

    // Stray responses with nothing in flight are ignored so the count never underflows.
    assign w_resp_take       = load_valid_i && (r_outstanding != '0);
    assign w_refill_resp     = w_resp_take && (r_state == c_ST_REFILL);
    assign w_outstanding_nxt = r_outstanding + c_OW'(w_accept) - c_OW'(w_resp_take);
    assign w_resp_cnt_nxt    = r_resp_cnt + c_CW'(w_refill_resp);
    assign w_lookup_hit      = (r_state == c_ST_LOOKUP) && cache_hit_i;

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (fetch_i) w_state_nxt = c_ST_LOOKUP;
            end
            c_ST_LOOKUP: begin
                if (cache_hit_i || invalidate_i || r_abort) w_state_nxt = c_ST_IDLE;
                else if (!stall_i)                          w_state_nxt = c_ST_REFILL;
            end
            c_ST_REFILL: begin
                if (invalidate_i)
                    w_state_nxt = (w_outstanding_nxt != '0) ? c_ST_DRAIN : c_ST_IDLE;
                else if ((w_resp_cnt_nxt == c_BW) && !stall_i)
                    w_state_nxt = c_ST_ALLOCATE;
            end
            c_ST_ALLOCATE: begin
                if (invalidate_i || !stall_i) w_state_nxt = c_ST_IDLE;
            end
            c_ST_DRAIN: begin
                if (w_outstanding_nxt == '0) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State, counters, abort flag and latched PC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_ST_IDLE;
            r_issue_cnt   <= '0;
            r_resp_cnt    <= '0;
            r_outstanding <= '0;
            r_abort       <= 1'b0;
            r_pc          <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            if (w_state_nxt == c_ST_IDLE)
                r_abort <= 1'b0;
            else if (invalidate_i && ((r_state == c_ST_REFILL) || (r_state == c_ST_ALLOCATE)))
                r_abort <= 1'b1;
            if (r_state == c_ST_IDLE) begin
                r_issue_cnt <= '0;
                r_resp_cnt  <= '0;
                if (fetch_i) r_pc <= program_counter_i[31:2];
            end else begin
                if (w_accept) r_issue_cnt <= r_issue_cnt + c_CW'(1);
                r_resp_cnt <= w_resp_cnt_nxt;
            end
        end
    end

    // Line buffer capture; runs under stall so no response is lost.
    always_ff @(posedge clk_i) begin
        if (w_refill_resp) r_buf[w_resp_ptr] <= load_data_i;
    end

    generate
        for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_line
            assign w_line[gi*32 +: 32] = r_buf[gi];
        end
    endgenerate

    // Fetch-side and cache-side outputs decoded from the current state.
    always_comb begin
        stall_fetch_o         = (r_state == c_ST_IDLE) ? fetch_i : 1'b1;
        cache_read_o          = (r_state == c_ST_IDLE) && fetch_i;
        cache_read_address_o  = (r_state == c_ST_IDLE) ? program_counter_i : {r_pc, 2'b00};
        valid_o               = 1'b0;
        instruction_o         = '0;
        cache_write_o         = 1'b0;
        cache_write_address_o = '0;
        cache_instruction_o   = '0;
        if (w_lookup_hit) begin
            valid_o       = !(invalidate_i || r_abort);
            instruction_o = cache_instruction_i;
        end else if (r_state == c_ST_ALLOCATE) begin
            valid_o               = !invalidate_i;
            instruction_o         = w_line;
            cache_write_o         = !invalidate_i;
            cache_write_address_o = w_line_base;
            cache_instruction_o   = w_line;
        end
    end

    assign load_request_o    = w_issue_window;
    assign load_address_o    = {r_pc[29:c_OFFSET], w_issue_ptr, 2'b00};
    assign load_invalidate_o = invalidate_i;

`ifdef CRITICAL_WORD_FIRST_EN
    assign word_valid_o = w_refill_resp && (r_resp_cnt == '0) && !r_abort && !invalidate_i;
    assign word_o       = word_valid_o ? load_data_i : '0;
`else
    assign word_valid_o = 1'b0;
    assign word_o       = '0;
`endif

endmodule
`default_nettype wire
